// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined main-decoder control path for the 5-stage core.
// Decodes the ID opcode into a control bundle, detects load-use hazards
// against EX, and carries the bundle through EX, MEM and WB with per-stage
// valid bits. Bubbles are inserted on stall, flush or an empty ID slot.
// Optional feature macro: CTRL_UPPER_IMM_EN (adds LUI/AUIPC decode).
module ctrl_pipe #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned OPC_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [OPC_W-1:0]      id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  flush,
  output logic                  stall,
  output logic                  illegal,
  output logic                  ex_valid,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic [1:0]            ex_alu_op,
  output logic                  mem_valid,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  localparam logic [OPC_W-1:0] OPC_R      = OPC_W'(7'b0110011);
  localparam logic [OPC_W-1:0] OPC_I      = OPC_W'(7'b0010011);
  localparam logic [OPC_W-1:0] OPC_LOAD   = OPC_W'(7'b0000011);
  localparam logic [OPC_W-1:0] OPC_STORE  = OPC_W'(7'b0100011);
  localparam logic [OPC_W-1:0] OPC_BRANCH = OPC_W'(7'b1100011);
  localparam logic [OPC_W-1:0] OPC_JAL    = OPC_W'(7'b1101111);
  localparam logic [OPC_W-1:0] OPC_JALR   = OPC_W'(7'b1100111);
`ifdef CTRL_UPPER_IMM_EN
  localparam logic [OPC_W-1:0] OPC_LUI    = OPC_W'(7'b0110111);
  localparam logic [OPC_W-1:0] OPC_AUIPC  = OPC_W'(7'b0010111);
`endif

  // ID-stage decode results
  logic       w_reg_write;
  logic       w_alu_src;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_mem_to_reg;
  logic       w_branch;
  logic       w_jump;
  logic [1:0] w_alu_op;
  logic       w_uses_rs1;
  logic       w_uses_rs2;
  logic       w_illegal_d;

  logic       w_src_match;
  logic       w_stall;
  logic       w_bubble;

  // EX stage registers
  logic                  r_ex_valid;
  logic                  r_ex_alu_src;
  logic                  r_ex_branch;
  logic                  r_ex_jump;
  logic [1:0]            r_ex_alu_op;
  logic                  r_ex_mem_read;
  logic                  r_ex_mem_write;
  logic                  r_ex_reg_write;
  logic                  r_ex_mem_to_reg;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  r_ex_illegal;

  // MEM stage registers
  logic                  r_mem_valid;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic                  r_mem_reg_write;
  logic                  r_mem_mem_to_reg;
  logic [REG_ADDR_W-1:0] r_mem_rd;

  // WB stage registers
  logic                  r_wb_valid;
  logic                  r_wb_reg_write;
  logic                  r_wb_mem_to_reg;
  logic [REG_ADDR_W-1:0] r_wb_rd;

  // Opcode decode; anything not listed is illegal with all controls low.
  always_comb begin
    w_reg_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_alu_op     = 2'b00;
    w_uses_rs1   = 1'b0;
    w_uses_rs2   = 1'b0;
    w_illegal_d  = 1'b0;
    case (id_opcode)
      OPC_R: begin
        w_reg_write = 1'b1;
        w_alu_op    = 2'b10;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      OPC_I: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_op    = 2'b11;
        w_uses_rs1  = 1'b1;
      end
      OPC_LOAD: begin
        w_reg_write  = 1'b1;
        w_mem_read   = 1'b1;
        w_alu_src    = 1'b1;
        w_mem_to_reg = 1'b1;
        w_uses_rs1   = 1'b1;
      end
      OPC_STORE: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      OPC_BRANCH: begin
        w_branch   = 1'b1;
        w_alu_op   = 2'b01;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OPC_JAL: begin
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
      end
      OPC_JALR: begin
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
        w_alu_src   = 1'b1;
        w_uses_rs1  = 1'b1;
      end
`ifdef CTRL_UPPER_IMM_EN
      OPC_LUI, OPC_AUIPC: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
      end
`endif
      default: w_illegal_d = 1'b1;
    endcase
  end

  // Load-use hazard against the load sitting in EX; x0 never hazards and a
  // flush wins because the ID instruction is being killed anyway.
  always_comb begin
    w_src_match = (w_uses_rs1 && (id_rs1 == r_ex_rd)) ||
                  (w_uses_rs2 && (id_rs2 == r_ex_rd));
    w_stall     = !rst && !flush && r_ex_valid && r_ex_mem_read &&
                  (r_ex_rd != '0) && id_valid && w_src_match;
    w_bubble    = flush || w_stall || !id_valid;
  end

  // EX stage: load the decoded bundle or insert a bubble.
  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_ex_valid      <= 1'b0;
      r_ex_alu_src    <= 1'b0;
      r_ex_branch     <= 1'b0;
      r_ex_jump       <= 1'b0;
      r_ex_alu_op     <= 2'b00;
      r_ex_mem_read   <= 1'b0;
      r_ex_mem_write  <= 1'b0;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_to_reg <= 1'b0;
      r_ex_rd         <= '0;
      r_ex_illegal    <= 1'b0;
    end else begin
      r_ex_valid      <= 1'b1;
      r_ex_alu_src    <= w_alu_src;
      r_ex_branch     <= w_branch;
      r_ex_jump       <= w_jump;
      r_ex_alu_op     <= w_alu_op;
      r_ex_mem_read   <= w_mem_read;
      r_ex_mem_write  <= w_mem_write;
      r_ex_reg_write  <= w_reg_write;
      r_ex_mem_to_reg <= w_mem_to_reg;
      r_ex_rd         <= id_rd;
      r_ex_illegal    <= w_illegal_d;
    end
  end

  // MEM stage: always advances from EX, even while ID is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_valid      <= 1'b0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_reg_write  <= 1'b0;
      r_mem_mem_to_reg <= 1'b0;
      r_mem_rd         <= '0;
    end else begin
      r_mem_valid      <= r_ex_valid;
      r_mem_read       <= r_ex_valid && r_ex_mem_read;
      r_mem_write      <= r_ex_valid && r_ex_mem_write;
      r_mem_reg_write  <= r_ex_valid && r_ex_reg_write;
      r_mem_mem_to_reg <= r_ex_valid && r_ex_mem_to_reg;
      r_mem_rd         <= r_ex_rd;
    end
  end

  // WB stage: always advances from MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_wb_rd         <= '0;
    end else begin
      r_wb_valid      <= r_mem_valid;
      r_wb_reg_write  <= r_mem_valid && r_mem_reg_write;
      r_wb_mem_to_reg <= r_mem_valid && r_mem_mem_to_reg;
      r_wb_rd         <= r_mem_rd;
    end
  end

  assign stall         = w_stall;
  assign illegal       = r_ex_valid && r_ex_illegal;
  assign ex_valid      = r_ex_valid;
  assign ex_alu_src    = r_ex_valid && r_ex_alu_src;
  assign ex_branch     = r_ex_valid && r_ex_branch;
  assign ex_jump       = r_ex_valid && r_ex_jump;
  assign ex_alu_op     = r_ex_valid ? r_ex_alu_op : 2'b00;
  assign mem_valid     = r_mem_valid;
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign wb_valid      = r_wb_valid;
  assign wb_reg_write  = r_wb_reg_write;
  assign wb_mem_to_reg = r_wb_mem_to_reg;
  assign wb_rd         = r_wb_rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed scenarios plus randomized traffic checked against a
// queue-of-instructions reference model of the control pipeline.
module tb_ctrl_pipe;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rd;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       flush;
  logic       stall;
  logic       illegal;
  logic       ex_valid;
  logic       ex_alu_src;
  logic       ex_branch;
  logic       ex_jump;
  logic [1:0] ex_alu_op;
  logic       mem_valid;
  logic       mem_read;
  logic       mem_write;
  logic       wb_valid;
  logic       wb_reg_write;
  logic       wb_mem_to_reg;
  logic [4:0] wb_rd;

  int errors = 0;
  int checks = 0;

  ctrl_pipe #(
    .REG_ADDR_W(5),
    .OPC_W     (7)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_rd        (id_rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .flush        (flush),
    .stall        (stall),
    .illegal      (illegal),
    .ex_valid     (ex_valid),
    .ex_alu_src   (ex_alu_src),
    .ex_branch    (ex_branch),
    .ex_jump      (ex_jump),
    .ex_alu_op    (ex_alu_op),
    .mem_valid    (mem_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg),
    .wb_rd        (wb_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each stage holds an instruction (or nothing); controls derive from it.
  typedef struct packed {
    logic       v;
    logic [6:0] op;
    logic [4:0] rd;
  } instr_t;

  instr_t m_ex, m_mem, m_wb;

  // Decode table: {legal, uses_rs1, uses_rs2, reg_write, alu_src, mem_read,
  //                mem_write, mem_to_reg, branch, jump, alu_op[1:0]}
  function automatic logic [11:0] dec(input logic [6:0] op);
    logic [11:0] d;
    d = 12'b0;
    case (op)
      OP_R:      d = {3'b111, 7'b1000000, 2'b10};
      OP_I:      d = {3'b110, 7'b1100000, 2'b11};
      OP_LOAD:   d = {3'b110, 7'b1110100, 2'b00};
      OP_STORE:  d = {3'b111, 7'b0101000, 2'b00};
      OP_BRANCH: d = {3'b111, 7'b0000010, 2'b01};
      OP_JAL:    d = {3'b100, 7'b1000001, 2'b00};
      OP_JALR:   d = {3'b110, 7'b1100001, 2'b00};
`ifdef CTRL_UPPER_IMM_EN
      OP_LUI, OP_AUIPC: d = {3'b100, 7'b1100000, 2'b00};
`endif
      default:   d = 12'b0;
    endcase
    return d;
  endfunction

  function automatic logic model_stall();
    logic [11:0] d;
    d = dec(id_opcode);
    if (rst || flush || !id_valid || !m_ex.v || m_ex.op != OP_LOAD || m_ex.rd == 5'd0)
      return 1'b0;
    return (d[10] && id_rs1 == m_ex.rd) || (d[9] && id_rs2 == m_ex.rd);
  endfunction

  // {ex_valid, ex_alu_src, ex_branch, ex_jump, ex_alu_op, illegal}
  function automatic logic [6:0] exp_ex(input instr_t s);
    logic [11:0] d;
    d = dec(s.op);
    if (!s.v) return 7'b0;
    return {1'b1, d[7], d[3], d[2], d[1:0], ~d[11]};
  endfunction

  function automatic logic [2:0] exp_mem(input instr_t s);
    logic [11:0] d;
    d = dec(s.op);
    if (!s.v) return 3'b0;
    return {1'b1, d[6], d[5]};
  endfunction

  function automatic logic [7:0] exp_wb(input instr_t s);
    logic [11:0] d;
    d = dec(s.op);
    if (!s.v) return 8'b0;
    return {1'b1, d[8], d[4], s.rd};
  endfunction

  // Advance one clock and the model alongside it; inputs change 1 ns after the edge.
  task automatic tick();
    logic st;
    instr_t nx;
    st = model_stall();
    nx = '0;
    if (id_valid && !flush && !st) nx = '{v: 1'b1, op: id_opcode, rd: id_rd};
    @(posedge clk);
    if (rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0;
    end else begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = nx;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic fl);
    id_valid = v; id_opcode = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; flush = fl;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    logic [19:0] outs;
    rst = 1'b1;
    drive(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    tick();
    outs = {stall, illegal, ex_valid, ex_alu_src, ex_branch, ex_jump, ex_alu_op, mem_valid,
            mem_read, mem_write, wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd};
    checks++;
    if (outs !== 20'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want all zero", outs);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({ex_valid, ex_alu_op} !== 3'b110) begin
      errors++;
      $display("FAIL reset_release: got valid/alu_op %b, want 110", {ex_valid, ex_alu_op});
    end
    idle(3);
  endtask

  task automatic test_pipeline();
    drive(1'b1, OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0);
    tick();
    idle(0);
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    checks++;
    if ({ex_valid, ex_alu_src} !== 2'b11) begin
      errors++;
      $display("FAIL pipe_ex: got valid/alu_src %b, want 11", {ex_valid, ex_alu_src});
    end
    tick();
    checks++;
    if ({mem_valid, mem_read, mem_write} !== 3'b110) begin
      errors++;
      $display("FAIL pipe_mem: got %b, want 110", {mem_valid, mem_read, mem_write});
    end
    tick();
    checks++;
    if ({wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd} !== {3'b111, 5'd5}) begin
      errors++;
      $display("FAIL pipe_wb: got %b, want 11100101",
               {wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd});
    end
    idle(3);
  endtask

  task automatic test_load_use();
    drive(1'b1, OP_LOAD, 5'd3, 5'd1, 5'd0, 1'b0);
    tick();
    drive(1'b1, OP_R, 5'd9, 5'd1, 5'd3, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall: got %b, want 1", stall);
    end
    tick();
    checks++;
    if ({ex_valid, stall} !== 2'b00) begin
      errors++;
      $display("FAIL load_use_bubble: got ex_valid/stall %b, want 00", {ex_valid, stall});
    end
    tick();
    checks++;
    if ({ex_valid, ex_alu_op} !== 3'b110) begin
      errors++;
      $display("FAIL load_use_retry: got %b, want 110", {ex_valid, ex_alu_op});
    end
    drive(1'b1, OP_LOAD, 5'd0, 5'd1, 5'd0, 1'b0);
    tick();
    drive(1'b1, OP_R, 5'd9, 5'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL load_use_x0: got %b, want 0", stall);
    end
    idle(3);
  endtask

  task automatic test_no_false_hazard();
    drive(1'b1, OP_LOAD, 5'd4, 5'd1, 5'd0, 1'b0);
    tick();
    drive(1'b1, OP_JAL, 5'd1, 5'd4, 5'd4, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL jal_no_hazard: got %b, want 0", stall);
    end
    idle(3);
  endtask

  task automatic test_flush_during_stall();
    drive(1'b1, OP_LOAD, 5'd7, 5'd1, 5'd0, 1'b0);
    tick();
    drive(1'b1, OP_BRANCH, 5'd0, 5'd7, 5'd2, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b, want 0", stall);
    end
    tick();
    checks++;
    if ({ex_valid, ex_branch} !== 2'b00) begin
      errors++;
      $display("FAIL flush_bubble: got %b, want 00", {ex_valid, ex_branch});
    end
    idle(3);
  endtask

  task automatic test_illegal();
    drive(1'b1, OP_LUI, 5'd6, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
`ifdef CTRL_UPPER_IMM_EN
    checks++;
    if ({ex_valid, illegal, ex_alu_src} !== 3'b101) begin
      errors++;
      $display("FAIL upper_imm_ex: got %b, want 101", {ex_valid, illegal, ex_alu_src});
    end
    tick();
    tick();
    checks++;
    if ({wb_valid, wb_reg_write} !== 2'b11) begin
      errors++;
      $display("FAIL upper_imm_wb: got %b, want 11", {wb_valid, wb_reg_write});
    end
`else
    checks++;
    if ({ex_valid, illegal, ex_alu_src, ex_branch, ex_jump, ex_alu_op} !== 7'b1100000) begin
      errors++;
      $display("FAIL illegal_ex: got %b, want 1100000",
               {ex_valid, illegal, ex_alu_src, ex_branch, ex_jump, ex_alu_op});
    end
    tick();
    tick();
    checks++;
    if ({wb_valid, wb_reg_write, wb_mem_to_reg} !== 3'b100) begin
      errors++;
      $display("FAIL illegal_wb: got %b, want 100", {wb_valid, wb_reg_write, wb_mem_to_reg});
    end
`endif
    idle(3);
  endtask

  task automatic test_random();
    logic [6:0] ops [0:10];
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
            OP_LUI, OP_AUIPC, 7'h00, 7'h7f};
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 9) < 8,
            ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)],
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (stall !== model_stall()) begin
        errors++;
        $display("FAIL rnd_stall cyc %0d: got %b, want %b", n, stall, model_stall());
      end
      tick();
      checks++;
      if ({ex_valid, ex_alu_src, ex_branch, ex_jump, ex_alu_op, illegal} !== exp_ex(m_ex)) begin
        errors++;
        $display("FAIL rnd_ex cyc %0d: got %b, want %b", n,
                 {ex_valid, ex_alu_src, ex_branch, ex_jump, ex_alu_op, illegal}, exp_ex(m_ex));
      end
      checks++;
      if ({mem_valid, mem_read, mem_write} !== exp_mem(m_mem)) begin
        errors++;
        $display("FAIL rnd_mem cyc %0d: got %b, want %b", n,
                 {mem_valid, mem_read, mem_write}, exp_mem(m_mem));
      end
      checks++;
      if ({wb_valid, wb_reg_write, wb_mem_to_reg, wb_valid ? wb_rd : 5'd0} !== exp_wb(m_wb)) begin
        errors++;
        $display("FAIL rnd_wb cyc %0d: got %b, want %b", n,
                 {wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd}, exp_wb(m_wb));
      end
    end
    rst = 1'b0;
    idle(3);
  endtask

  initial begin
    m_ex = '0; m_mem = '0; m_wb = '0;
    rst = 1'b1;
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    test_reset();
    test_pipeline();
    test_load_use();
    test_no_false_hazard();
    test_flush_during_stall();
    test_illegal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Pipelined successor to the combinational main decoder.
- Decodes the ID-stage opcode into the control bundle and carries it through the EX, MEM and WB pipeline registers with per-stage valid bits.
- Detects load-use hazards against the EX stage and generates the stall.
- Inserts bubbles on stall or branch/jump flush.
- Sits between the instruction register and the datapath stage registers of the 5-stage core.

Parameters:
- REG_ADDR_W, 5, register index width (rd/rs1/rs2).
- OPC_W, 7, opcode field width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  OPC_W  ID instruction opcode
- id_rd  in  REG_ADDR_W  destination register
- id_rs1  in  REG_ADDR_W  source register 1
- id_rs2  in  REG_ADDR_W  source register 2
- flush  in  1  taken branch/jump resolved in EX; kill the ID instruction
- stall  out  1  load-use hazard; freeze PC and IF/ID (combinational)
- illegal  out  1  registered; EX holds a valid undecodable opcode
- ex_valid, ex_alu_src, ex_branch, ex_jump  out  1 each  EX-stage controls
- ex_alu_op  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
- mem_valid, mem_read, mem_write  out  1 each  MEM-stage controls
- wb_valid, wb_reg_write, wb_mem_to_reg  out  1 each  WB-stage controls
- wb_rd  out  REG_ADDR_W  WB destination register

Behaviour:
- Reset (rst high at a clk edge): all stage registers clear, so every valid, control, alu_op, rd and illegal output is 0. stall reads 0 while rst is high.
- Decode (combinational, ID), default all 0:
  - R 0110011: reg_write; alu_op=10; uses rs1 and rs2.
  - I 0010011: reg_write, alu_src; alu_op=11; uses rs1.
  - LOAD 0000011: reg_write, mem_read, alu_src, mem_to_reg; alu_op=00; uses rs1.
  - STORE 0100011: mem_write, alu_src; alu_op=00; uses rs1 and rs2.
  - BRANCH 1100011: branch; alu_op=01; uses rs1 and rs2.
  - JAL 1101111: reg_write, jump; alu_op=00; no sources.
  - JALR 1100111: reg_write, jump, alu_src; alu_op=00; uses rs1.
  - Any other opcode: all controls 0, illegal_d=1.
- Hazard (combinational): stall = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((uses_rs1 & id_rs1 == ex_rd) | (uses_rs2 & id_rs2 == ex_rd)). ex_rd is held internally. stall is forced to 0 when flush=1.
- Pipeline advance every cycle, 1-cycle latency per stage, no global enable:
  - EX <= bubble if flush | stall | !id_valid; otherwise the decoded bundle with ex_valid=1.
  - A bubble clears valid and every control bit, and clears illegal.
  - MEM <= EX and WB <= MEM unconditionally. The stall does not freeze later stages; the load continues.
  - Control bits in every stage are ANDed with that stage's valid, so an invalid stage never asserts any control.
- Priority: rst > flush > stall > normal.
- flush and stall in the same cycle: bubble; stall output 0. The ID instruction is discarded, not retried.
- illegal: set in EX when the decoded opcode is illegal and the instruction is valid and not bubbled. Tracks the EX stage only.
- The decode is not gated by rd==0; only the hazard compare excludes x0.

Optional Feature:
- Macro CTRL_UPPER_IMM_EN.
- Defined: LUI 0110111 and AUIPC 0010111 decode as reg_write, alu_src, alu_op=00, no sources used, illegal_d=0.
- Undefined: both opcodes decode as illegal with all controls 0.

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1, opcode 0110011 -> all outputs 0. Release -> ex_valid=1, ex_alu_op=10 one cycle later.
- Pipeline: issue LOAD rd=5 -> next cycles: ex_alu_src=1; then mem_read=1; then wb_reg_write=1, wb_mem_to_reg=1, wb_rd=5.
- Load-use: LOAD rd=3, then R-type rs2=3 -> stall=1 for exactly one cycle and EX gets a bubble; the held R-type then enters EX with ex_valid=1. With rd=0 instead -> stall stays 0.
- No false hazard: LOAD rd=4, then JAL with rs1 field=4 -> stall=0 (JAL uses no sources).
- Flush during stall: LOAD rd=7, then BRANCH rs1=7 with flush=1 -> stall=0 and ex_valid=0 next cycle.
- Illegal/optional: opcode 0110111 -> illegal=1 and no controls without CTRL_UPPER_IMM_EN. With the macro -> illegal=0, ex_alu_src=1, wb_reg_write=1 two cycles later.
